// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit completions,
// with a one-entry holding register per requester and a registered broadcast.
module cdb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [N_REQ-1:0]          fu_valid,
    input  logic [N_REQ*TAG_W-1:0]    fu_tag,
    input  logic [N_REQ*DATA_W-1:0]   fu_data,
    output logic [N_REQ-1:0]          fu_stall,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [$clog2(N_REQ)-1:0]  cdb_src
);

    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  held_valid;
    logic [TAG_W-1:0]  held_tag  [N_REQ];
    logic [DATA_W-1:0] held_data [N_REQ];
    logic [SRC_W-1:0]  rr_ptr;

    logic [TAG_W-1:0]  in_tag  [N_REQ];
    logic [DATA_W-1:0] in_data [N_REQ];
    logic [N_REQ-1:0]  eff_req;

    logic              grant_any;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W:0]    scan_sum;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic [SRC_W-1:0]  rr_next;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign in_tag[i]  = fu_tag[i*TAG_W +: TAG_W];
        assign in_data[i] = fu_data[i*DATA_W +: DATA_W];
        // A held entry masks any new result presented while stalled
        assign eff_req[i] = held_valid[i] | fu_valid[i];
    end

    // Scan upward from rr_ptr with wrap; first effective request wins
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan_sum >= (SRC_W+1)'(N_REQ))
                scan_sum = scan_sum - (SRC_W+1)'(N_REQ);
            if (!grant_any && eff_req[scan_sum[SRC_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan_sum[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        win_tag  = held_valid[grant_idx] ? held_tag[grant_idx]  : in_tag[grant_idx];
        win_data = held_valid[grant_idx] ? held_data[grant_idx] : in_data[grant_idx];
        rr_next  = (grant_idx == SRC_W'(N_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            held_valid <= '0;
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else if (squash) begin
            held_valid <= '0;
            cdb_valid  <= 1'b0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_tag  <= win_tag;
                cdb_data <= win_data;
                cdb_src  <= grant_idx;
                rr_ptr   <= rr_next;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (held_valid[i]) begin
                    if (grant_any && grant_idx == SRC_W'(i))
                        held_valid[i] <= 1'b0;
                end else if (fu_valid[i] && !(grant_any && grant_idx == SRC_W'(i))) begin
                    held_valid[i] <= 1'b1;
                    held_tag[i]   <= in_tag[i];
                    held_data[i]  <= in_data[i];
                end
            end
        end
    end

    assign fu_stall = held_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset, squash;
    logic [N-1:0]    fu_valid;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_data;
    logic [N-1:0]    fu_stall;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_stall  (fu_stall),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit            mh_v [N];
    logic [TW-1:0] mh_t [N];
    logic [DW-1:0] mh_d [N];
    int            m_rr;
    bit            m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_src;
    int            stall_run [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply the arbitration rules to the current inputs; call before the edge
    task automatic model_update();
        int g;
        g = -1;
        if (reset) begin
            for (int i = 0; i < N; i++) mh_v[i] = 1'b0;
            m_rr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
        end else if (squash) begin
            for (int i = 0; i < N; i++) mh_v[i] = 1'b0;
            m_valid = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (g < 0 && (mh_v[i] || fu_valid[i])) g = i;
            end
            for (int i = 0; i < N; i++)
                if (i != g && !mh_v[i] && fu_valid[i]) begin
                    mh_v[i] = 1'b1;
                    mh_t[i] = fu_tag[i*TW +: TW];
                    mh_d[i] = fu_data[i*DW +: DW];
                end
            if (g >= 0) begin
                m_valid = 1'b1;
                m_src   = g;
                if (mh_v[g]) begin
                    m_tag = mh_t[g]; m_data = mh_d[g]; mh_v[g] = 1'b0;
                end else begin
                    m_tag = fu_tag[g*TW +: TW]; m_data = fu_data[g*DW +: DW];
                end
                m_rr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_stall;
        model_update();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) exp_stall[i] = mh_v[i];
        check("cdb_valid", cdb_valid, m_valid);
        check("cdb_tag",   cdb_tag,   m_tag);
        check("cdb_data",  cdb_data,  m_data);
        check("cdb_src",   cdb_src,   m_src);
        check("fu_stall",  fu_stall,  exp_stall);
        for (int i = 0; i < N; i++) begin
            if (fu_stall[i] === 1'b1) begin
                stall_run[i]++;
                check("starvation_bound", stall_run[i] <= N - 1, 1);
            end else begin
                stall_run[i] = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
        for (int i = 0; i < N; i++) stall_run[i] = 0;
        step(); step();
        check("rst_valid", cdb_valid, 0);
        check("rst_tag",   cdb_tag,   0);
        check("rst_data",  cdb_data,  0);
        check("rst_src",   cdb_src,   0);
        check("rst_stall", fu_stall,  0);

        // Single request after reset
        reset = 1'b0; fu_valid = 4'b0001; fu_tag[5:0] = 6'd5; fu_data[31:0] = 32'hA;
        step();
        check("single_valid", cdb_valid, 1);
        check("single_tag",   cdb_tag,   5);
        check("single_data",  cdb_data,  32'hA);
        check("single_src",   cdb_src,   0);
        check("single_stall", fu_stall,  4'b0000);
        fu_valid = '0;
        step();
        check("idle_valid",    cdb_valid, 0);
        check("idle_tag_hold", cdb_tag,   5);

        // All four at once from rr_ptr=0
        reset = 1'b1; step(); reset = 1'b0;
        fu_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            fu_tag[i*TW +: TW]  = TW'(i + 1);
            fu_data[i*DW +: DW] = DW'(100 + i);
        end
        step();
        check("all4_src0",   cdb_src,  0);
        check("all4_tag0",   cdb_tag,  1);
        check("all4_stall0", fu_stall, 4'b1110);
        fu_valid = '0;
        step();
        check("all4_src1",   cdb_src,  1);
        check("all4_tag1",   cdb_tag,  2);
        check("all4_stall1", fu_stall, 4'b1100);
        step();
        check("all4_src2",   cdb_src,  2);
        check("all4_stall2", fu_stall, 4'b1000);
        step();
        check("all4_src3",   cdb_src,  3);
        check("all4_tag3",   cdb_tag,  4);
        check("all4_data3",  cdb_data, 103);
        check("all4_stall3", fu_stall, 4'b0000);

        // Wrap from rr_ptr=3
        fu_valid = 4'b0100; step();
        fu_valid = 4'b1001; step();
        check("wrap_first",  cdb_src,  3);
        check("wrap_stall",  fu_stall, 4'b0001);
        fu_valid = '0; step();
        check("wrap_second", cdb_src,  0);
        check("wrap_valid",  cdb_valid, 1);
        fu_valid = 4'b1111; step();
        check("rr_after_wrap", cdb_src, 1);
        check("three_held",    fu_stall, 4'b1101);

        // Squash with three held entries
        squash = 1'b1; fu_valid = 4'b0001; step();
        check("squash_valid", cdb_valid, 0);
        check("squash_stall", fu_stall,  4'b0000);
        squash = 1'b0; fu_valid = '0;
        repeat (3) begin
            step();
            check("squash_no_bcast", cdb_valid, 0);
        end
        fu_valid = 4'b1111;
        for (int i = 0; i < N; i++) fu_tag[i*TW +: TW] = TW'(40 + i);
        step();
        check("squash_rr_kept", cdb_src, 2);
        check("squash_new_tag", cdb_tag, 42);
        fu_valid = '0;
        repeat (4) step();

        // Requester 2 streaming alone
        for (int c = 0; c < 6; c++) begin
            fu_valid = fu_stall[2] ? 4'b0000 : 4'b0100;
            fu_data[2*DW +: DW] = DW'(500 + c);
            step();
            check("stream_valid", cdb_valid, 1);
            check("stream_src",   cdb_src,   2);
            check("stream_stall", fu_stall[2], 0);
        end

        // Reset beats squash with held entries
        fu_valid = 4'b1111; step();
        reset = 1'b1; squash = 1'b1; fu_valid = 4'b1111; step();
        check("rs_valid", cdb_valid, 0);
        check("rs_tag",   cdb_tag,   0);
        check("rs_data",  cdb_data,  0);
        check("rs_src",   cdb_src,   0);
        check("rs_stall", fu_stall,  0);
        reset = 1'b0; squash = 1'b0; fu_valid = 4'b1111; step();
        check("rs_rr_zero", cdb_src, 0);

        // Randomized traffic, mostly honouring back-pressure
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(199) == 0);
            squash = ($urandom_range(49) == 0);
            for (int i = 0; i < N; i++) begin
                fu_valid[i] = ($urandom_range(2) != 0) &&
                              (!fu_stall[i] || $urandom_range(9) == 0);
                fu_tag[i*TW +: TW]  = TW'($urandom);
                fu_data[i*DW +: DW] = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of functional-unit completion requesters (2..8).
REQ-002 The block SHALL have parameter TAG_W, default 6, meaning the physical register tag width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the result width.
REQ-004 The block SHALL have port clock  input  1  system clock; the block uses this one clock only, all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port squash  input  1  interrupt/mispredict flush, synchronous.
REQ-007 The block SHALL have port fu_valid  input  N_REQ  per-requester completion valid.
REQ-008 The block SHALL have port fu_tag  input  N_REQ*TAG_W  per-requester destination tag, requester i in bits [i*TAG_W +: TAG_W].
REQ-009 The block SHALL have port fu_data  input  N_REQ*DATA_W  per-requester result, same packing as fu_tag.
REQ-010 The block SHALL have port fu_stall  output  N_REQ  per-requester back-pressure; requester shall not present a new result while its bit is high.
REQ-011 The block SHALL have port cdb_valid  output  1  broadcast valid.
REQ-012 The block SHALL have port cdb_tag  output  TAG_W  broadcast tag.
REQ-013 The block SHALL have port cdb_data  output  DATA_W  broadcast result.
REQ-014 The block SHALL have port cdb_src  output  clog2(N_REQ)  index of requester that owns the broadcast.

Function
REQ-015 Each requester SHALL own a one-entry holding register (held_valid, held_tag, held_data).
REQ-016 Effective request of requester i SHALL be held_valid[i] OR fu_valid[i]; when held_valid[i] is set, the held entry SHALL be the candidate and fu_valid[i] SHALL be ignored (protocol violation, no state change from it).
REQ-017 Grant SHALL be round-robin: the lowest index i, searching upward from rr_ptr with wrap from N_REQ-1 to 0, whose effective request is high.
REQ-018 At most one grant SHALL occur per cycle; with no requests, no grant occurs and rr_ptr is unchanged.
REQ-019 On a grant to index g, rr_ptr SHALL become (g+1) mod N_REQ at the next edge.
REQ-020 Granted candidate SHALL appear on cdb_valid=1, cdb_tag, cdb_data, cdb_src=g at the next edge (1-cycle latency, registered outputs); a cycle without grant SHALL drive cdb_valid=0 next cycle, with tag/data/src held at prior values.
REQ-021 A new fu_valid[i] result not granted in its arrival cycle SHALL be captured into holding register i at the edge.
REQ-022 A held entry that is granted SHALL clear held_valid[i] at the edge.
REQ-023 fu_stall[i] SHALL equal the registered held_valid[i] (no combinational path from fu_valid to fu_stall).
REQ-024 Starvation bound: any pending effective request SHALL be granted within N_REQ cycles.
REQ-025 squash SHALL have priority over all other inputs except reset: at the edge, all held_valid clear, cdb_valid becomes 0, inputs of that cycle are discarded, rr_ptr is preserved.
REQ-026 Results SHALL pass unmodified; no tag is treated specially.

Reset
REQ-027 While reset is high at an edge: held_valid all 0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, fu_stall all 0.
REQ-028 Reset asserted mid-operation SHALL discard held entries and any pending broadcast with no partial output; reset has priority over squash.

Verification (N_REQ=4)
REQ-029 After reset, fu_valid=0001, tag 5, data 32'hA -> next cycle cdb_valid=1, cdb_tag=5, cdb_data=32'hA, cdb_src=0; rr_ptr=1; fu_stall=0000.
REQ-030 rr_ptr=0, fu_valid=1111 in one cycle (tags 1..4), then 0000 -> broadcasts on four consecutive cycles with src 0,1,2,3; fu_stall=1110, then 1100, 1000, 0000 on successive cycles.
REQ-031 rr_ptr=3, fu_valid=1001 -> src 3 first, then src 0 next cycle (wrap); rr_ptr ends at 1.
REQ-032 Requester 2 presents every cycle it is not stalled, others idle -> cdb_valid high every cycle with src 2, fu_stall[2] never asserts.
REQ-033 Three entries held, squash asserted with fu_valid=0001 -> next cycle cdb_valid=0, fu_stall=0000, no later broadcast of any discarded result; rr_ptr unchanged.
REQ-034 Reset asserted same cycle as squash and fu_valid=1111 with entries held -> next cycle all REQ-027 values, rr_ptr=0.
